// File: rtl/core_mem_arbiter_if.sv
// core_mem_arbiter_if: one request/grant memory port (req + fields out, gnt/err/rdata back).
// The requester side uses the master modport, the responder side the slave modport.
interface core_mem_arbiter_if #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_STRB_W = MEM_DATA_W / 8
);
    logic                  req;
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wen;
    logic [MEM_STRB_W-1:0] strb;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  gnt;
    logic                  err;
    logic [MEM_DATA_W-1:0] rdata;

    modport master (
        output req, addr, wen, strb, wdata,
        input  gnt, err, rdata
    );

    modport slave (
        input  req, addr, wen, strb, wdata,
        output gnt, err, rdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: merges the core imem and dmem ports onto one registered memory port.
// Default build gives dmem fixed priority. Defining CORE_MEM_ARBITER_ROUND_ROBIN_EN
// makes simultaneous requests alternate, tracked by a one-bit last_owner register.
module core_mem_arbiter #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_STRB_W = MEM_DATA_W / 8
) (
    input  logic               f_clk,
    input  logic               g_resetn,
    core_mem_arbiter_if.slave  imem,
    core_mem_arbiter_if.slave  dmem,
    core_mem_arbiter_if.master mem
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  wen;
        logic [MEM_STRB_W-1:0] strb;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_fields_t;

    state_t      state, state_nxt;
    mem_fields_t lat;
    logic        gnt_bubble;   // high for the one IDLE cycle right after a completion
    logic        pick_d;       // dmem wins if it is requesting and allowed to

`ifdef CORE_MEM_ARBITER_ROUND_ROBIN_EN
    logic last_owner;          // 1 = imem completed last, 0 = dmem (reset value)

    // dmem wins alone, or on a tie when imem was the last one served
    always_comb pick_d = dmem.req && (!imem.req || last_owner);

    // remember who completed last so the next tie goes to the other port
    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn)                           last_owner <= 1'b0;
        else if (mem.gnt && state == BUSY_I)     last_owner <= 1'b1;
        else if (mem.gnt && state == BUSY_D)     last_owner <= 1'b0;
    end
`else
    // fixed priority: dmem always wins a tie
    always_comb pick_d = dmem.req;
`endif

    // state register; reset kills any in-flight transaction
    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) state <= IDLE;
        else           state <= state_nxt;
    end

    // next state: sample in IDLE (except the bubble cycle), leave BUSY on mem_gnt
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!gnt_bubble) begin
                    if (pick_d)        state_nxt = BUSY_D;
                    else if (imem.req) state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem.gnt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // the cycle after a grant is a bubble: the granted port's req is still the
    // stale value then, so sampling waits one cycle and nothing is reissued
    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) gnt_bubble <= 1'b0;
        else           gnt_bubble <= (state != IDLE) && mem.gnt;
    end

    // latch the winner's fields on the IDLE->BUSY transition; held while busy
    always_ff @(posedge f_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lat <= '0;
        end else if (state == IDLE && state_nxt == BUSY_D) begin
            lat <= '{addr: dmem.addr, wen: dmem.wen, strb: dmem.strb, wdata: dmem.wdata};
        end else if (state == IDLE && state_nxt == BUSY_I) begin
            lat <= '{addr: imem.addr, wen: imem.wen, strb: imem.strb, wdata: imem.wdata};
        end
    end

    // downstream request is a pure decode of registered state, no path from core inputs
    always_comb begin
        mem.req   = (state != IDLE);
        mem.addr  = lat.addr;
        mem.wen   = lat.wen;
        mem.strb  = lat.strb;
        mem.wdata = lat.wdata;
    end

    // route the response to the owner only; a port that dropped req loses it
    always_comb begin
        imem.gnt   = 1'b0;
        imem.err   = 1'b0;
        imem.rdata = '0;
        dmem.gnt   = 1'b0;
        dmem.err   = 1'b0;
        dmem.rdata = '0;
        if (mem.gnt) begin
            if (state == BUSY_I && imem.req) begin
                imem.gnt   = 1'b1;
                imem.err   = mem.err;
                imem.rdata = mem.rdata;
            end
            if (state == BUSY_D && dmem.req) begin
                dmem.gnt   = 1'b1;
                dmem.err   = mem.err;
                dmem.rdata = mem.rdata;
            end
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: table vectors, directed corner sequences and a randomized
// run against a transaction-level model of core_mem_arbiter.
module tb_core_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 8;

`ifdef CORE_MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [SW-1:0] strb;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        bit            is_d;
        req_t          f;
        int            dly;
        logic          m_err;
        logic [DW-1:0] m_rdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic f_clk = 1'b0;
    logic g_resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    core_mem_arbiter_if #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW)) imem_bus ();
    core_mem_arbiter_if #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW)) dmem_bus ();
    core_mem_arbiter_if #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW)) mem_bus ();

    core_mem_arbiter #(.MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_STRB_W(SW)) dut (
        .f_clk    (f_clk),
        .g_resetn (g_resetn),
        .imem     (imem_bus),
        .dmem     (dmem_bus),
        .mem      (mem_bus)
    );

    always #5 f_clk = ~f_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit d, input logic rq, input req_t f);
        if (d) begin
            dmem_bus.req = rq; dmem_bus.addr = f.addr; dmem_bus.wen = f.wen;
            dmem_bus.strb = f.strb; dmem_bus.wdata = f.wdata;
        end else begin
            imem_bus.req = rq; imem_bus.addr = f.addr; imem_bus.wen = f.wen;
            imem_bus.strb = f.strb; imem_bus.wdata = f.wdata;
        end
    endtask

    task automatic mem_resp(input logic g, input logic e, input logic [DW-1:0] rd);
        mem_bus.gnt = g; mem_bus.err = e; mem_bus.rdata = rd;
    endtask

    function automatic logic port_gnt(input bit d);
        return d ? dmem_bus.gnt : imem_bus.gnt;
    endfunction
    function automatic logic port_err(input bit d);
        return d ? dmem_bus.err : imem_bus.err;
    endfunction
    function automatic logic [DW-1:0] port_rdata(input bit d);
        return d ? dmem_bus.rdata : imem_bus.rdata;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.addr  = {$urandom, $urandom};
        r.wen   = 1'($urandom_range(0, 1));
        r.strb  = 8'($urandom);
        r.wdata = {$urandom, $urandom};
        return r;
    endfunction

    task automatic chk_fields(input string tag, input req_t f);
        chk({tag, ".addr"},  mem_bus.addr, f.addr);
        chk({tag, ".wen"},   64'(mem_bus.wen), 64'(f.wen));
        chk({tag, ".strb"},  64'(mem_bus.strb), 64'(f.strb));
        chk({tag, ".wdata"}, mem_bus.wdata, f.wdata);
    endtask

    // reset pulse; all outputs must read zero even with a response driven
    task automatic do_reset();
        @(negedge f_clk);
        g_resetn = 1'b0;
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        mem_resp(1'b1, 1'b1, '1);
        #1;
        chk("rst.mem_req", 64'(mem_bus.req), 0);
        chk_fields("rst", '0);
        chk("rst.imem_gnt", 64'(imem_bus.gnt), 0);
        chk("rst.dmem_gnt", 64'(dmem_bus.gnt), 0);
        chk("rst.imem_err", 64'(imem_bus.err), 0);
        chk("rst.dmem_err", 64'(dmem_bus.err), 0);
        chk("rst.imem_rdata", imem_bus.rdata, 0);
        chk("rst.dmem_rdata", dmem_bus.rdata, 0);
        @(negedge f_clk);
        mem_resp(1'b0, 1'b0, '0);
        g_resetn = 1'b1;
    endtask

    // one single-port transaction from the table
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        @(negedge f_clk);
        drive(v.is_d, 1'b1, v.f);
        mem_resp(1'b0, 1'b1, '1);              // junk err/rdata without gnt
        #1;
        chk({t, ".req_pre"}, 64'(mem_bus.req), 0);
        @(negedge f_clk);
        #1;
        chk({t, ".req_lat1"}, 64'(mem_bus.req), 1);
        chk_fields(t, v.f);
        for (int k = 0; k < v.dly; k++) begin
            chk({t, ".wait_gnt"}, 64'(port_gnt(v.is_d)), 0);
            chk({t, ".wait_rdata"}, port_rdata(v.is_d), 0);
            @(negedge f_clk);
            #1;
        end
        mem_resp(1'b1, v.m_err, v.m_rdata);
        #1;
        chk({t, ".gnt"}, 64'(port_gnt(v.is_d)), 1);
        chk({t, ".err"}, 64'(port_err(v.is_d)), 64'(v.exp_err));
        chk({t, ".rdata"}, port_rdata(v.is_d), v.exp_rdata);
        chk({t, ".other_gnt"}, 64'(port_gnt(!v.is_d)), 0);
        chk({t, ".other_err"}, 64'(port_err(!v.is_d)), 0);
        chk({t, ".other_rdata"}, port_rdata(!v.is_d), 0);
        chk_fields({t, ".held"}, v.f);
        @(negedge f_clk);
        drive(v.is_d, 1'b0, v.f);
        mem_resp(1'b0, 1'b0, '0);
        #1;
        chk({t, ".req_post"}, 64'(mem_bus.req), 0);
        @(negedge f_clk);
    endtask

    vec_t vecs[4];

    initial begin
        int   order[$];
        int   rise[$];
        logic prev;
        logic g_i, g_d;
        int   cyc;
        req_t fi, fd;

        // model state for the random run
        int      owner, last;
        bit      bubble;
        bit      rq[2], drop[2];
        req_t    fld[2], lat;
        logic    g, e;
        logic [DW-1:0] rd;

        vecs[0] = '{is_d: 1'b0, f: '{64'h0000_0000_8000_0000, 1'b0, 8'h00, 64'h0}, dly: 2,
                    m_err: 1'b0, m_rdata: 64'h0000_0013_0000_0093,
                    exp_err: 1'b0, exp_rdata: 64'h0000_0013_0000_0093};
        vecs[1] = '{is_d: 1'b1, f: '{64'h1000, 1'b1, 8'h0F, 64'hDEAD_BEEF}, dly: 0,
                    m_err: 1'b1, m_rdata: 64'h0,
                    exp_err: 1'b1, exp_rdata: 64'h0};
        vecs[2] = '{is_d: 1'b1, f: '{64'h2008, 1'b0, 8'h00, 64'h0}, dly: 1,
                    m_err: 1'b0, m_rdata: 64'h0123_4567_89AB_CDEF,
                    exp_err: 1'b0, exp_rdata: 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{is_d: 1'b0, f: '{64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF}, dly: 3,
                    m_err: 1'b1, m_rdata: 64'hA5A5_A5A5_5A5A_5A5A,
                    exp_err: 1'b1, exp_rdata: 64'hA5A5_A5A5_5A5A_5A5A};

        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        mem_resp(1'b0, 1'b0, '0);
        do_reset();

        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // simultaneous requests, immediate grants: order and mem_req rise cycles
        do_reset();
        fi = '{64'h100, 1'b0, 8'h00, 64'h0};
        fd = '{64'h200, 1'b1, 8'h3C, 64'h1234};
        prev = 1'b0; g_i = 1'b0; g_d = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge f_clk);
            if (c == 0) begin drive(1'b0, 1'b1, fi); drive(1'b1, 1'b1, fd); end
            if (g_i) drive(1'b0, 1'b0, fi);
            if (g_d) drive(1'b1, 1'b0, fd);
            mem_resp(mem_bus.req, 1'b0, 64'(c));
            #1;
            g_i = imem_bus.gnt; g_d = dmem_bus.gnt;
            if (mem_bus.req && !prev) rise.push_back(c);
            prev = mem_bus.req;
            if (g_i) order.push_back(0);
            if (g_d) order.push_back(1);
        end
        chk("sim.n_grants", 64'(order.size()), 2);
        chk("sim.n_rises", 64'(rise.size()), 2);
        if (order.size() == 2) begin
            chk("sim.first", 64'(order[0]), RR ? 0 : 1);
            chk("sim.second", 64'(order[1]), RR ? 1 : 0);
        end
        if (rise.size() == 2) begin
            chk("sim.rise0", 64'(rise[0]), 1);
            chk("sim.rise1", 64'(rise[1]), 4);
        end
        mem_resp(1'b0, 1'b0, '0);

        // both ports requesting continuously for 8 transactions
        do_reset();
        order.delete();
        drive(1'b0, 1'b1, fi);
        drive(1'b1, 1'b1, fd);
        cyc = 0;
        while (order.size() < 8 && cyc < 60) begin
            @(negedge f_clk);
            mem_resp(mem_bus.req, 1'b0, '0);
            #1;
            if (imem_bus.gnt) order.push_back(0);
            if (dmem_bus.gnt) order.push_back(1);
            cyc++;
        end
        chk("cont.count", 64'(order.size()), 8);
        for (int k = 0; k < order.size(); k++)
            chk($sformatf("cont.owner%0d", k), 64'(order[k]), RR ? 64'(k % 2) : 1);
        @(negedge f_clk);
        drive(1'b0, 1'b0, fi);
        drive(1'b1, 1'b0, fd);
        mem_resp(1'b0, 1'b0, '0);

        // reset while BUSY_D, dmem_req held through it
        do_reset();
        fd = '{64'hCAFE_0000, 1'b1, 8'hF0, 64'h7777};
        @(negedge f_clk);
        drive(1'b1, 1'b1, fd);
        @(negedge f_clk);
        #1;
        chk("rstmid.busy", 64'(mem_bus.req), 1);
        @(negedge f_clk);
        g_resetn = 1'b0;
        mem_resp(1'b1, 1'b0, 64'h55);
        #1;
        chk("rstmid.mem_req", 64'(mem_bus.req), 0);
        chk("rstmid.mem_addr", mem_bus.addr, 0);
        chk("rstmid.dmem_gnt", 64'(dmem_bus.gnt), 0);
        chk("rstmid.imem_gnt", 64'(imem_bus.gnt), 0);
        @(negedge f_clk);
        g_resetn = 1'b1;
        mem_resp(1'b0, 1'b0, '0);
        #1;
        chk("rstmid.idle", 64'(mem_bus.req), 0);
        @(negedge f_clk);
        #1;
        chk("rstmid.reissue", 64'(mem_bus.req), 1);
        chk_fields("rstmid", fd);
        mem_resp(1'b1, 1'b0, 64'h99);
        #1;
        chk("rstmid.gnt", 64'(dmem_bus.gnt), 1);
        chk("rstmid.rdata", dmem_bus.rdata, 64'h99);
        @(negedge f_clk);
        drive(1'b1, 1'b0, fd);
        mem_resp(1'b0, 1'b0, '0);

        // spurious mem_gnt in IDLE
        do_reset();
        @(negedge f_clk);
        mem_resp(1'b1, 1'b1, 64'hFFFF);
        #1;
        chk("spur.imem_gnt", 64'(imem_bus.gnt), 0);
        chk("spur.dmem_gnt", 64'(dmem_bus.gnt), 0);
        chk("spur.imem_rdata", imem_bus.rdata, 0);
        chk("spur.dmem_rdata", dmem_bus.rdata, 0);
        chk("spur.dmem_err", 64'(dmem_bus.err), 0);
        @(negedge f_clk);
        mem_resp(1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, fi);
        #1;
        chk("spur.idle", 64'(mem_bus.req), 0);
        @(negedge f_clk);
        #1;
        chk("spur.accept", 64'(mem_bus.req), 1);
        mem_resp(1'b1, 1'b0, '0);
        #1;
        @(negedge f_clk);
        drive(1'b0, 1'b0, fi);
        mem_resp(1'b0, 1'b0, '0);

        // randomized traffic against a transaction-level model
        do_reset();
        owner = -1; last = 1; bubble = 1'b0;
        rq = '{1'b0, 1'b0}; drop = '{1'b0, 1'b0};
        fld[0] = '0; fld[1] = '0; lat = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge f_clk);
            for (int p = 0; p < 2; p++) begin
                if (drop[p]) begin
                    rq[p] = 1'b0; drop[p] = 1'b0;
                end else if (!rq[p] && $urandom_range(0, 2) == 0) begin
                    rq[p] = 1'b1; fld[p] = rand_req();
                end
                drive(p == 1, rq[p], fld[p]);
            end
            g  = (owner >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            e  = 1'($urandom_range(0, 1));
            rd = {$urandom, $urandom};
            mem_resp(g, e, rd);
            #1;
            chk("rnd.mem_req", 64'(mem_bus.req), 64'(owner >= 0));
            if (owner >= 0) chk_fields("rnd", lat);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rnd.gnt%0d", p), 64'(port_gnt(p == 1)), 64'(owner == p && g));
                chk($sformatf("rnd.err%0d", p), 64'(port_err(p == 1)), 64'((owner == p && g) ? e : 1'b0));
                chk($sformatf("rnd.rdata%0d", p), port_rdata(p == 1), (owner == p && g) ? rd : 64'h0);
            end
            if (owner >= 0) begin
                if (g) begin
                    last = owner; drop[owner] = 1'b1; owner = -1; bubble = 1'b1;
                end
            end else if (bubble) begin
                bubble = 1'b0;
            end else begin
                if (rq[0] && rq[1]) owner = RR ? ((last == 1) ? 0 : 1) : 1;
                else if (rq[1])     owner = 1;
                else if (rq[0])     owner = 0;
                if (owner >= 0) lat = fld[owner];
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Two-to-one memory arbiter directly downstream of core_top.
- Merges the core's imem and dmem request/grant interfaces onto a single memory port for single-ported SRAM or a bus bridge.
- Registers the selected request, so the downstream port has no combinational path from core request outputs.
- Routes the downstream grant, error and read data back to the owning core port.

Parameters:
- MEM_ADDR_W, 64, request address width
- MEM_DATA_W, 64, read/write data width
- MEM_STRB_W, 8, write strobe width (MEM_DATA_W/8)

Ports:
- f_clk  in  1  global clock, all state on rising edge
- g_resetn  in  1  asynchronous active-low reset
- imem_req  in  1  instruction-side request, held until imem_gnt
- imem_addr  in  MEM_ADDR_W  instruction request address
- imem_wen  in  1  instruction request write enable
- imem_strb  in  MEM_STRB_W  instruction write strobe
- imem_wdata  in  MEM_DATA_W  instruction write data
- imem_gnt  out  1  instruction response valid
- imem_err  out  1  instruction response error
- imem_rdata  out  MEM_DATA_W  instruction read data
- dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata  in  as imem_*  data-side request
- dmem_gnt, dmem_err, dmem_rdata  out  as imem_*  data-side response
- mem_req  out  1  merged request, registered
- mem_addr  out  MEM_ADDR_W  merged address, registered
- mem_wen  out  1  merged write enable, registered
- mem_strb  out  MEM_STRB_W  merged strobe, registered
- mem_wdata  out  MEM_DATA_W  merged write data, registered
- mem_gnt  in  1  downstream response valid, only meaningful while mem_req=1
- mem_err  in  1  downstream response error, qualified by mem_gnt
- mem_rdata  in  MEM_DATA_W  downstream read data, qualified by mem_gnt

Behaviour:
- Handshake on every port:
  - req rises, then addr/wen/strb/wdata stay stable until the cycle gnt=1.
  - gnt, err and rdata are valid in that same cycle.
  - The transaction completes on that edge; a new request may be presented the following cycle.
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- IDLE:
  - dmem_req=1 → BUSY_D; latch dmem_addr/wen/strb/wdata into the mem_* registers.
  - else imem_req=1 → BUSY_I; latch the imem_* fields.
  - else stay in IDLE.
- Latency: mem_req rises one cycle after the upstream req is sampled in IDLE.
- BUSY_x:
  - mem_req=1 with the latched fields; fields do not change while busy.
  - On mem_gnt=1: x_gnt=mem_gnt, x_err=mem_err, x_rdata=mem_rdata, combinationally in the same cycle. Next state IDLE; mem_req deasserts next cycle.
- Minimum throughput: one transaction per 3 cycles (sample, request, grant-return bubble).
- Response routing:
  - Non-owner port: gnt=0, err=0, rdata=0.
  - In IDLE: all upstream gnt/err/rdata are 0.
  - mem_err and mem_rdata are ignored unless mem_gnt=1.
- mem_gnt=1 while in IDLE is a protocol violation: ignored, no upstream gnt produced.
- Upstream req dropping before its gnt is illegal. The arbiter completes the latched transaction regardless and discards the response.
- Reset:
  - All outputs reset to 0: mem_req/addr/wen/strb/wdata, and all upstream gnt/err/rdata.
  - Reset asserted mid-transaction forces IDLE and mem_req=0 immediately (asynchronous); the in-flight response is lost.
- Simultaneous imem_req and dmem_req in IDLE: dmem wins. imem is served at the next IDLE if still requesting.

Optional Feature:
- Macro: CORE_MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - One-bit last_owner register, reset to 0 (data).
  - On a simultaneous request in IDLE, the port not equal to last_owner wins.
  - last_owner updates on every completed transaction (mem_gnt in BUSY_x).
  - With both ports continuously requesting, service alternates I, D, I, D...
- Not defined: fixed dmem priority as above; no last_owner register.

Test Plan:
- imem read at addr 0x80000000, mem_gnt returned 2 cycles after mem_req with rdata 0x00000013_00000093 → mem_req rises 1 cycle after imem_req; imem_gnt=1 with imem_rdata 0x00000013_00000093; dmem_gnt stays 0.
- dmem write, addr 0x1000, strb 0x0F, wdata 0xDEADBEEF, mem_gnt=1 with mem_err=1 → mem_wen=1, mem_strb=0x0F; dmem_gnt=1 and dmem_err=1 in the same cycle; imem_err=0.
- imem_req and dmem_req both asserted in the same cycle, grants returned immediately → default build: dmem served first, then imem, mem_req high cycles 2 and 5. With CORE_MEM_ARBITER_ROUND_ROBIN_EN after reset: imem served first.
- Both ports requesting continuously for 8 transactions → default build: imem never granted. With round robin: 4 grants each, strictly alternating.
- g_resetn pulsed low while in BUSY_D, before mem_gnt → mem_req=0 and all gnt=0 during reset; FSM in IDLE after release; a held dmem_req is re-sampled and re-issued.
- Spurious mem_gnt=1 in IDLE with mem_rdata=0xFFFF → imem_gnt=dmem_gnt=0, both rdata=0, state unchanged.
